// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states plus command and response byte codes.
// The same constants are used by the keyboard receiver and translator.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SEND,
        STOP,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on clock and data, a FILTER_LEN glitch
// filter on the clock, and a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic Reloj,
    input  logic RST,
    input  logic ps2c_in,
    input  logic ps2d_in,
    output logic clk_filt,
    output logic data_sync,
    output logic fall
);

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] hist;

    // Idle PS/2 lines float high, so everything resets to the released level.
    always_ff @(posedge Reloj or posedge RST) begin
        if (RST) begin
            c_sync   <= 2'b11;
            d_sync   <= 2'b11;
            hist     <= '1;
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            c_sync <= {c_sync[0], ps2c_in};
            d_sync <= {d_sync[0], ps2d_in};
            hist   <= {hist[FILTER_LEN-2:0], c_sync[1]};
            fall   <= 1'b0;
            if (&hist) begin
                clk_filt <= 1'b1;
            end else if (~|hist) begin
                clk_filt <= 1'b0;
                fall     <= clk_filt;
            end
        end
    end

    assign data_sync = d_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one odd-parity command
// frame on device-generated clocks and reports ACK, NACK or timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 12000,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic       Reloj,
    input  logic       RST,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout,
    output logic       rx_inhibit
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYC - 2);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);

    tx_state_t        state, state_nxt;
    logic [INH_W-1:0] inh_cnt, inh_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt, to_inc;
    logic [3:0]       idx, idx_nxt;
    logic [8:0]       frame, frame_nxt;
    logic             ack_bad, ack_bad_nxt;
    logic             c_oe_nxt, d_oe_nxt, busy_nxt;
    logic             done_nxt, err_nxt, tout_nxt;
    logic             clk_filt, data_sync, fall;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .Reloj     (Reloj),
        .RST       (RST),
        .ps2c_in   (ps2c_in),
        .ps2d_in   (ps2d_in),
        .clk_filt  (clk_filt),
        .data_sync (data_sync),
        .fall      (fall)
    );

    always_ff @(posedge Reloj or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            idx        <= '0;
            frame      <= '0;
            ack_bad    <= 1'b0;
            ps2c_oe    <= 1'b0;
            ps2d_oe    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_ack_err <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            inh_cnt    <= inh_nxt;
            to_cnt     <= to_nxt;
            idx        <= idx_nxt;
            frame      <= frame_nxt;
            ack_bad    <= ack_bad_nxt;
            ps2c_oe    <= c_oe_nxt;
            ps2d_oe    <= d_oe_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
            tx_ack_err <= err_nxt;
            tx_timeout <= tout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        inh_nxt     = inh_cnt;
        to_nxt      = to_cnt;
        idx_nxt     = idx;
        frame_nxt   = frame;
        ack_bad_nxt = ack_bad;
        c_oe_nxt    = 1'b0;
        d_oe_nxt    = ps2d_oe;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        tout_nxt    = 1'b0;
        to_inc      = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);

        case (state)
            IDLE: begin
                inh_nxt  = '0;
                to_nxt   = '0;
                d_oe_nxt = 1'b0;
                if (tx_start) begin
                    frame_nxt = {~^tx_data, tx_data};
                    c_oe_nxt  = 1'b1;
                    state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                c_oe_nxt = 1'b1;
                inh_nxt  = inh_cnt + INH_W'(1);
                // Start bit goes low while the clock is still held, so it is valid at release.
                if (inh_cnt == INH_DATA) d_oe_nxt = 1'b1;
                if (inh_cnt == INH_LAST) begin
                    c_oe_nxt  = 1'b0;
                    d_oe_nxt  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                to_nxt    = to_inc;
                idx_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: begin
                to_nxt = to_inc;
                if (fall) begin
                    d_oe_nxt  = ~frame[0];
                    frame_nxt = frame >> 1;
                    idx_nxt   = idx + 4'd1;
                    if (idx == 4'd8) state_nxt = STOP;
                end
            end
            STOP: begin
                to_nxt = to_inc;
                if (fall) begin
                    d_oe_nxt  = 1'b0;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                to_nxt = to_inc;
                if (fall) begin
                    ack_bad_nxt = data_sync;
                    state_nxt   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                to_nxt = to_inc;
                if (clk_filt && data_sync) begin
                    done_nxt  = ~ack_bad;
                    err_nxt   = ack_bad;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A stalled device aborts the frame; this overrides a coincident ACK edge.
        if ((state inside {RELEASE, SEND, STOP, ACK, WAIT_IDLE}) && (to_inc == TO_MAX)) begin
            state_nxt = IDLE;
            c_oe_nxt  = 1'b0;
            d_oe_nxt  = 1'b0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
            tout_nxt  = 1'b1;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    assign rx_inhibit = tx_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with pull-ups, a keyboard model that clocks
// frames out of the host, table vectors, random frames and multi-cycle corner cases.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TMO = 3000;
    localparam int HP  = 25;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       kbd_c = 1'b0;
    logic       kbd_d = 1'b0;
    logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_ack_err, tx_timeout, rx_inhibit;
    wire        ps2c_line = ~(ps2c_oe | kbd_c);
    wire        ps2d_line = ~(ps2d_oe | kbd_d);

    int checks = 0;
    int failures = 0;
    string cur = "reset";

    int cyc = 0;
    int n_done = 0, n_err = 0, n_to = 0, n_rxmis = 0;
    int inh_run = 0, last_inh = 0, rel_cyc = 0, to_cyc = 0;
    logic prev_doe = 1'b0, start_at_rel = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         ack_val;
        bit         glitch;
        bit         stray;
        bit         exp_par;
        bit         exp_done;
        bit         exp_err;
    } vec_t;
    vec_t vecs[6];

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TMO),
        .FILTER_LEN  (8)
    ) dut (
        .Reloj      (clk),
        .RST        (RST),
        .ps2c_in    (ps2c_line),
        .ps2d_in    (ps2d_line),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .ps2c_oe    (ps2c_oe),
        .ps2d_oe    (ps2d_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_ack_err (tx_ack_err),
        .tx_timeout (tx_timeout),
        .rx_inhibit (rx_inhibit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus observer: inhibit length, start bit at release, pulse counts.
    always @(negedge clk) begin
        if (ps2c_oe) begin
            inh_run = inh_run + 1;
        end else if (inh_run != 0) begin
            last_inh     = inh_run;
            start_at_rel = prev_doe;
            rel_cyc      = cyc;
            inh_run      = 0;
        end
        prev_doe = ps2d_oe;
        if (tx_done)    n_done = n_done + 1;
        if (tx_ack_err) n_err  = n_err + 1;
        if (tx_timeout) begin
            n_to   = n_to + 1;
            to_cyc = cyc;
        end
        if (rx_inhibit !== tx_busy) n_rxmis = n_rxmis + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s/%s: actual=%0h required=%0h", cur, name, act, exp);
        end
    endtask

    // Keyboard model: waits for the host request, then clocks n_bits cells.
    task automatic kbd_frame(input int n_bits, input bit ack_val, input bit glitch,
                             output logic [9:0] cap);
        int t;
        cap = '0;
        t = 0;
        while (ps2c_line !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        chk("req_seen", {31'd0, ps2c_line}, 32'd0);
        t = 0;
        while (ps2c_line !== 1'b1 && t < INH + 100) begin @(negedge clk); t++; end
        chk("clk_released", {31'd0, ps2c_line}, 32'd1);
        chk("start_bit", {31'd0, ps2d_line}, 32'd0);
        repeat (HP) @(negedge clk);
        for (int i = 0; i < n_bits; i++) begin
            kbd_c = 1'b1;
            repeat (HP) @(negedge clk);
            if (i < 10) cap[i] = ps2d_line;
            kbd_c = 1'b0;
            if (i == 9)  kbd_d = ~ack_val;
            if (i == 10) kbd_d = 1'b0;
            if (glitch && i < 10) begin
                repeat (12) @(negedge clk);
                kbd_c = 1'b1;
                repeat (3) @(negedge clk);
                kbd_c = 1'b0;
                repeat (HP - 15) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int d0, e0, o0, r0, t;
        logic [9:0] cap;
        d0 = n_done; e0 = n_err; o0 = n_to; r0 = n_rxmis;
        start_tx(v.data);
        chk("busy_set", {31'd0, tx_busy}, 32'd1);
        fork
            kbd_frame(11, v.ack_val, v.glitch, cap);
            begin
                if (v.stray) begin
                    repeat (20) @(negedge clk);
                    tx_data = CMD_ENABLE; tx_start = 1'b1;
                    @(negedge clk); tx_start = 1'b0;
                    repeat (130) @(negedge clk);
                    tx_data = CMD_ENABLE; tx_start = 1'b1;
                    @(negedge clk); tx_start = 1'b0;
                end
            end
        join
        t = 0;
        while (n_done == d0 && n_err == e0 && n_to == o0 && t < 200) begin @(negedge clk); t++; end
        repeat (30) @(negedge clk);
        chk("data_bits", {24'd0, cap[7:0]}, {24'd0, v.data});
        chk("parity", {31'd0, cap[8]}, {31'd0, v.exp_par});
        chk("stop", {31'd0, cap[9]}, 32'd1);
        chk("inhibit_len", last_inh, INH);
        chk("start_before_release", {31'd0, start_at_rel}, 32'd1);
        chk("done_cnt", n_done - d0, {31'd0, v.exp_done});
        chk("ackerr_cnt", n_err - e0, {31'd0, v.exp_err});
        chk("timeout_cnt", n_to - o0, 32'd0);
        chk("busy_idle", {31'd0, tx_busy}, 32'd0);
        chk("lines_released", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
        chk("rx_inhibit", n_rxmis - r0, 32'd0);
    endtask

    initial begin
        vec_t rv;
        logic [9:0] cap;
        int o0, d0, e0, t;

        vecs[0] = '{CMD_SET_LED, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h01,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{CMD_ECHO,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{CMD_SET_LED, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_outputs", {25'd0, ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_ack_err,
                            tx_timeout, rx_inhibit}, 32'd0);
        RST = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cur = $sformatf("vec%0d", i);
            run_frame(vecs[i]);
        end

        // Timeout: no device clocks after release.
        cur = "timeout";
        o0 = n_to; d0 = n_done; e0 = n_err;
        start_tx(CMD_RESET);
        t = 0;
        while (n_to == o0 && t < TMO + 300) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        chk("timeout_cnt", n_to - o0, 32'd1);
        chk("timeout_delay", to_cyc - rel_cyc, TMO);
        chk("no_done", (n_done - d0) + (n_err - e0), 32'd0);
        chk("lines_released", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
        chk("busy_idle", {31'd0, tx_busy}, 32'd0);
        cur = "after_timeout";
        run_frame(vecs[0]);

        // Asynchronous reset in the middle of a frame.
        cur = "midreset";
        start_tx(8'h00);
        kbd_frame(4, 1'b0, 1'b0, cap);
        chk("busy_pre", {31'd0, tx_busy}, 32'd1);
        chk("doe_pre", {31'd0, ps2d_oe}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("async_clear", {29'd0, ps2c_oe, ps2d_oe, tx_busy}, 32'd0);
        repeat (3) @(negedge clk);
        RST = 1'b0;
        repeat (5) @(negedge clk);
        cur = "after_reset";
        run_frame(vecs[2]);

        // Random frames against a parity/ack model.
        for (int i = 0; i < 8; i++) begin
            rv.data     = 8'($urandom_range(0, 255));
            rv.ack_val  = ($urandom_range(0, 3) == 0);
            rv.glitch   = 1'($urandom_range(0, 1));
            rv.stray    = 1'b0;
            rv.exp_par  = ($countones(rv.data) % 2 == 0);
            rv.exp_done = !rv.ack_val;
            rv.exp_err  = rv.ack_val;
            cur = $sformatf("rand%0d_%02h", i, rv.data);
            run_frame(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
